// File: rtl/pointer_uart_tx.sv
// pointer_uart_tx
// Byte-oriented UART transmitter (8N1, LSB first, idle high) fronted by a
// 4-entry FIFO. The bit period is chosen per frame from CLKS_PER_BIT or
// CLKS_PER_BIT_OC, depending on overclock at the moment the frame starts.
//
// Ports:
//   clk             system clock, all logic on posedge
//   reset_n         synchronous active-low reset
//   overclock       selects CLKS_PER_BIT_OC for the next frame started
//   flush           empties the FIFO (the frame on the line is not affected)
//   serial_in_write 1-cycle write strobe, no backpressure
//   serial_in_data  byte to enqueue with serial_in_write
//   txd             serial line output
//   busy            a frame is on the line or bytes are queued
//   level           FIFO occupancy 0..4
//   overflow        sticky, a write was dropped because the FIFO was full
module pointer_uart_tx #(
  parameter int CLKS_PER_BIT    = 25000,
  parameter int CLKS_PER_BIT_OC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       overclock,
  input  logic       flush,
  input  logic       serial_in_write,
  input  logic [7:0] serial_in_data,
  output logic       txd,
  output logic       busy,
  output logic [2:0] level,
  output logic       overflow
);

  localparam int MAX_CLKS = (CLKS_PER_BIT > CLKS_PER_BIT_OC) ? CLKS_PER_BIT : CLKS_PER_BIT_OC;
  localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam logic [CNT_W-1:0] PERIOD_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PERIOD_OC_M1 = CNT_W'(CLKS_PER_BIT_OC - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [0:3];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [7:0]       shift_q, shift_next;
  logic [2:0]       bit_idx, bit_next, bit_inc;
  logic [CNT_W-1:0] cnt, cnt_next, period_m1, period_next;
  logic             txd_next;
  logic             pop, push, drop, can_pop, cnt_done;
  logic [2:0]       level_next;

  // A pop is only allowed when bytes are queued and no flush is pending;
  // flush takes priority so a same-cycle pop never consumes a discarded byte.
  assign can_pop  = (level != 3'd0) && !flush;
  assign cnt_done = (cnt == '0);
  assign bit_inc  = bit_idx + 3'd1;

  // Transmit FSM next-state and datapath. Starting a frame (from IDLE or
  // straight out of the last STOP cycle) latches the head byte and the bit
  // period, so overclock changes mid-frame only affect the following frame.
  always_comb begin
    state_next  = state;
    shift_next  = shift_q;
    bit_next    = bit_idx;
    cnt_next    = cnt;
    period_next = period_m1;
    txd_next    = txd;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (can_pop) begin
          pop         = 1'b1;
          state_next  = START;
          shift_next  = mem[rd_ptr];
          period_next = overclock ? PERIOD_OC_M1 : PERIOD_M1;
          cnt_next    = overclock ? PERIOD_OC_M1 : PERIOD_M1;
          txd_next    = 1'b0;
        end
      end
      START: begin
        if (cnt_done) begin
          state_next = DATA;
          cnt_next   = period_m1;
          bit_next   = 3'd0;
          txd_next   = shift_q[0];
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_next = period_m1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next = bit_inc;
            txd_next = shift_q[bit_inc];
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          if (can_pop) begin
            pop         = 1'b1;
            state_next  = START;
            shift_next  = mem[rd_ptr];
            period_next = overclock ? PERIOD_OC_M1 : PERIOD_M1;
            cnt_next    = overclock ? PERIOD_OC_M1 : PERIOD_M1;
            txd_next    = 1'b0;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // FIFO admission. A full FIFO still accepts a write when the head is
  // popped in the same cycle, because a slot frees up on that edge.
  always_comb begin
    push       = serial_in_write && !flush && ((level != 3'd4) || pop);
    drop       = serial_in_write && !flush && (level == 3'd4) && !pop;
    level_next = level;
    if (flush) begin
      level_next = 3'd0;
    end else begin
      case ({push, pop})
        2'b10:   level_next = level + 3'd1;
        2'b01:   level_next = level - 3'd1;
        default: level_next = level;
      endcase
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      shift_q   <= 8'd0;
      bit_idx   <= 3'd0;
      cnt       <= '0;
      period_m1 <= '0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      level     <= 3'd0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      txd       <= txd_next;
      shift_q   <= shift_next;
      bit_idx   <= bit_next;
      cnt       <= cnt_next;
      period_m1 <= period_next;
      level     <= level_next;
      if (drop) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

  // FIFO storage carries no reset; stale entries are never read because
  // level gates every pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= serial_in_data;
  end

  assign busy = (state != IDLE) || (level != 3'd0);

endmodule

// File: tb/tb_pointer_uart_tx.sv
// tb_pointer_uart_tx
// Self-checking bench for pointer_uart_tx. A reference model built from a
// byte queue and a "cycles left in the current frame" countdown predicts
// txd, level, busy and overflow after every clock edge.
module tb_pointer_uart_tx;

  localparam int NORM = 8;
  localparam int OC   = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       overclock = 1'b0;
  logic       flush = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       txd, busy, overflow;
  logic [2:0] level;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [7:0] q[$];
  int         rem = 0;
  int         cur_p = NORM;
  logic [7:0] cur_byte = 8'h00;
  logic       m_ovf = 1'b0;
  int         peak = 0;

  pointer_uart_tx #(.CLKS_PER_BIT(NORM), .CLKS_PER_BIT_OC(OC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .overclock(overclock),
    .flush(flush),
    .serial_in_write(wr),
    .serial_in_data(wdata),
    .txd(txd),
    .busy(busy),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Line level expected from the position within the current frame:
  // slot 0 is the start bit, slots 1..8 are data LSB first, slot 9 is stop.
  function automatic logic expTxd();
    int el, slot;
    if (rem == 0) return 1'b1;
    el   = 10 * cur_p - rem;
    slot = el / cur_p;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur_byte[slot - 1];
  endfunction

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic modelEdge();
    logic popped;
    if (!reset_n) begin
      q.delete();
      rem   = 0;
      m_ovf = 1'b0;
      return;
    end
    popped = !flush && (q.size() > 0) && (rem <= 1);
    if (popped) begin
      cur_byte = q.pop_front();
      cur_p    = overclock ? OC : NORM;
      rem      = 10 * cur_p;
    end else if (rem > 0) begin
      rem--;
    end
    if (flush) q.delete();
    else if (wr) begin
      if (q.size() < 4) q.push_back(wdata);
      else m_ovf = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic f, input logic oc, input logic rn);
    logic [5:0] expv, obsv;
    wr = w; wdata = d; flush = f; overclock = oc; reset_n = rn;
    @(posedge clk);
    modelEdge();
    #1;
    expv = {expTxd(), 3'(q.size()), (rem != 0) || (q.size() != 0), m_ovf};
    obsv = {txd, level, busy, overflow};
    checkOutput("txd/level/busy/ovf", 32'(obsv), 32'(expv));
    if (int'(level) > peak) peak = int'(level);
  endtask

  task automatic stepIdle();
    applyStimulus(1'b0, 8'h00, 1'b0, overclock, 1'b1);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      stepIdle();
    end
    checkOutput("drain_timeout", 32'(busy), 32'd0);
  endtask

  logic [9:0] ca_seq;
  logic [7:0] rb;

  initial begin
    ca_seq = 10'b1110010100;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    stepIdle();

    // Single byte 0xCA: latency and mid-bit sequence
    applyStimulus(1'b1, 8'hCA, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_level", 32'(level), 32'd1);
    checkOutput("lat_txd_high", 32'(txd), 32'd1);
    stepIdle();
    checkOutput("lat_txd_low", 32'(txd), 32'd0);
    for (int c = 0; c < 10 * NORM; c++) begin
      if (c % NORM == NORM / 2) checkOutput($sformatf("ca_bit%0d", c / NORM), 32'(txd), 32'(ca_seq[c / NORM]));
      stepIdle();
    end
    checkOutput("busy_after_stop", 32'(busy), 32'd0);
    stepIdle();

    // Burst of three on consecutive cycles
    peak = 0;
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h85, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h82, 1'b0, 1'b0, 1'b1);
    waitDrain(40 * NORM);
    checkOutput("burst_peak", 32'(peak), 32'd2);

    // Six writes: one popped, four queued, sixth dropped
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_level", 32'(level), 32'd4);
    waitDrain(60 * NORM);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Overclocked frame, overclock dropped mid-frame with a byte queued
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 10 * OC; c++) begin
      if (c == 3 * OC) applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
      else stepIdle();
      if (c == 10 * OC - 2) checkOutput("oc_stop_high", 32'(txd), 32'd1);
    end
    checkOutput("oc_next_start", 32'(txd), 32'd0);
    waitDrain(20 * NORM);

    // Flush during the first frame's data bits
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4 * NORM && (10 * cur_p - rem) < 3 * cur_p; i++) stepIdle();
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_mid_busy", 32'(busy), 32'd1);
    waitDrain(20 * NORM);
    stepIdle();
    checkOutput("flush_idle_txd", 32'(txd), 32'd1);

    // Flush on the same cycle as the stop-bit pop
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12 * NORM && rem != 1; i++) stepIdle();
    checkOutput("fp_reach_stop_end", 32'(rem), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("fp_busy", 32'(busy), 32'd0);
    checkOutput("fp_txd", 32'(txd), 32'd1);
    stepIdle();

    // Reset during data bit 4 with overflow already set
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8 * NORM && (10 * cur_p - rem) / cur_p != 5; i++) stepIdle();
    checkOutput("rst_pre_ovf", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic w, f, oc, rn;
      w  = ($urandom_range(0, 6) == 0);
      f  = ($urandom_range(0, 199) == 0);
      oc = ($urandom_range(0, 99) == 0) ? ~overclock : overclock;
      rn = ($urandom_range(0, 799) != 0);
      rb = 8'($urandom);
      applyStimulus(w, rb, f, oc, rn);
    end
    waitDrain(60 * NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
